// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_ctrl
// Description : Paced ADC sample capture into memory with overrun, abort and
//               configuration checking.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_ctrl #(
    parameter int MEM_SIZE   = 10000,
    parameter int MIN_PERIOD = 240
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic [9:0]                 i_adc_freq,
    input  logic [$clog2(MEM_SIZE):0]  i_ddr_size,
    output logic                       o_adc_conv,
    input  logic                       i_adc_done,
    input  logic [31:0]                i_adc_data,
    output logic                       o_wr_valid,
    input  logic                       i_wr_ready,
    output logic [$clog2(MEM_SIZE)-1:0] o_wr_addr,
    output logic [31:0]                o_wr_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [1:0]                 o_err,
    output logic [$clog2(MEM_SIZE):0]  o_sample_cnt
);

    localparam int c_aw = $clog2(MEM_SIZE);
    localparam int c_cw = c_aw + 1;
    localparam logic [9:0]      c_min_period = 10'(MIN_PERIOD);
    localparam logic [c_cw-1:0] c_mem_size   = c_cw'(MEM_SIZE);
    localparam logic [1:0]      c_err_none    = 2'd0;
    localparam logic [1:0]      c_err_config  = 2'd1;
    localparam logic [1:0]      c_err_overrun = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_CONV        = 3'd1,
        S_WAIT_ADC    = 3'd2,
        S_WRITE       = 3'd3,
        S_WAIT_PERIOD = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [9:0]        r_period;
    logic [9:0]        r_period_cnt;
    logic [c_cw-1:0]   r_size;
    logic [c_cw-1:0]   r_sample_cnt;
    logic [31:0]       r_wr_data;
    logic [1:0]        r_err;

    logic              w_cfg_bad;
    logic              w_period_end;
    logic [c_cw-1:0]   w_cnt_inc;
    logic              w_accept;
    logic              w_reject;
    logic              w_capture;
    logic              w_handshake;
    logic              w_overrun;

    assign w_cfg_bad    = (i_adc_freq < c_min_period) || (i_ddr_size == '0) ||
                          (i_ddr_size > c_mem_size);
    assign w_period_end = (r_period_cnt == (r_period - 10'd1));
    assign w_cnt_inc    = r_sample_cnt + c_cw'(1);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_capture    = 1'b0;
        w_handshake  = 1'b0;
        w_overrun    = 1'b0;
        // An abort outranks every other event in any active state.
        if (r_state != S_IDLE && i_stop) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_cfg_bad) begin
                            w_reject = 1'b1;
                        end else begin
                            w_accept     = 1'b1;
                            w_state_next = S_CONV;
                        end
                    end
                end
                S_CONV: w_state_next = S_WAIT_ADC;
                S_WAIT_ADC: begin
                    if (w_period_end) begin
                        w_overrun    = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (i_adc_done) begin
                        w_capture    = 1'b1;
                        w_state_next = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_period_end) begin
                        w_overrun    = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (i_wr_ready) begin
                        w_handshake  = 1'b1;
                        w_state_next = (w_cnt_inc == r_size) ? S_DONE : S_WAIT_PERIOD;
                    end
                end
                S_WAIT_PERIOD: begin
                    if (w_period_end) begin
                        w_state_next = S_CONV;
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_period     <= '0;
            r_period_cnt <= '0;
            r_size       <= '0;
            r_sample_cnt <= '0;
            r_wr_data    <= '0;
            r_err        <= c_err_none;
        end else begin
            r_state <= w_state_next;
            // Counter reads 0 during the CONV cycle, so the next CONV lands
            // exactly r_period clocks later.
            r_period_cnt <= (w_state_next == S_CONV) ? 10'd0 : r_period_cnt + 10'd1;
            if (w_reject) begin
                r_err <= c_err_config;
            end
            if (w_accept) begin
                r_period     <= i_adc_freq;
                r_size       <= i_ddr_size;
                r_sample_cnt <= '0;
                r_err        <= c_err_none;
            end
            if (w_overrun) begin
                r_err <= c_err_overrun;
            end
            if (w_capture) begin
                r_wr_data <= i_adc_data;
            end
            if (w_handshake) begin
                r_sample_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_adc_conv   = (r_state == S_CONV);
    assign o_wr_valid   = (r_state == S_WRITE);
    assign o_busy       = (r_state inside {S_CONV, S_WAIT_ADC, S_WRITE, S_WAIT_PERIOD});
    assign o_done       = (r_state == S_DONE);
    assign o_wr_addr    = r_sample_cnt[c_aw-1:0];
    assign o_wr_data    = r_wr_data;
    assign o_err        = r_err;
    assign o_sample_cnt = r_sample_cnt;

endmodule
`default_nettype wire

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 10000: maximum samples per capture.
REQ-002 SHALL have parameter MIN_PERIOD, default 240: minimum legal sample period in clocks.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL provide ports as follows (clock and reset first):
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle capture request.
- i_stop  in  1  single-cycle abort request.
- i_adc_freq  in  10  sample period in clocks.
- i_ddr_size  in  $clog2(MEM_SIZE)+1  samples to capture.
- o_adc_conv  out  1  one-cycle conversion-start pulse to the ADC front end.
- i_adc_done  in  1  one-cycle pulse: i_adc_data valid.
- i_adc_data  in  32  converted sample.
- o_wr_valid  out  1  memory write request.
- i_wr_ready  in  1  memory accepts write when o_wr_valid & i_wr_ready.
- o_wr_addr  out  $clog2(MEM_SIZE)  sample index.
- o_wr_data  out  32  sample to store.
- o_busy  out  1  capture in progress.
- o_done  out  1  one-cycle pulse: capture complete.
- o_err  out  2  sticky error code: 0 none, 1 bad config, 2 overrun.
- o_sample_cnt  out  $clog2(MEM_SIZE)+1  samples written in current/last capture.

Function
REQ-005 SHALL implement FSM states IDLE, CONV, WAIT_ADC, WRITE, WAIT_PERIOD, DONE.
REQ-006 IDLE: on i_start, if i_adc_freq < MIN_PERIOD, or i_ddr_size == 0, or i_ddr_size > MEM_SIZE, SHALL stay IDLE and set o_err=1 next cycle.
REQ-007 IDLE: on i_start with legal config SHALL latch i_adc_freq and i_ddr_size, clear o_err and o_sample_cnt, set o_busy, go to CONV.
REQ-008 Latched config SHALL be used for the whole capture; input changes mid-capture SHALL have no effect.
REQ-009 CONV: SHALL assert o_adc_conv for exactly one cycle, reset period counter to 0, go to WAIT_ADC.
REQ-010 Period counter SHALL increment every cycle after CONV; a period ends when counter == latched period - 1.
REQ-011 WAIT_ADC: on i_adc_done SHALL register i_adc_data into o_wr_data, set o_wr_valid, go to WRITE.
REQ-012 WRITE: o_wr_valid, o_wr_addr, o_wr_data SHALL remain stable until i_wr_ready; on handshake drop o_wr_valid, increment o_sample_cnt and address.
REQ-013 After handshake: if o_sample_cnt (post-increment) == latched size go to DONE, else WAIT_PERIOD.
REQ-014 WAIT_PERIOD: at period end SHALL go to CONV, so successive o_adc_conv pulses are exactly latched period clocks apart.
REQ-015 Overrun: if period ends while in WAIT_ADC or WRITE, SHALL set o_err=2, drop o_wr_valid, clear o_busy, go to IDLE without o_done.
REQ-016 i_adc_done outside WAIT_ADC SHALL be ignored.
REQ-017 DONE: SHALL pulse o_done one cycle, clear o_busy, return to IDLE.
REQ-018 i_stop in any non-IDLE state SHALL return to IDLE next cycle, clear o_busy and o_wr_valid, no o_done, o_err unchanged; i_stop has priority over all other events in the same cycle.
REQ-019 i_start while o_busy=1 SHALL be ignored.
REQ-020 o_wr_addr SHALL equal o_sample_cnt truncated to $clog2(MEM_SIZE) bits; first address 0, last size-1.
REQ-021 o_sample_cnt and o_err SHALL hold their values in IDLE until the next accepted or rejected i_start.

Reset
REQ-022 On i_rst=1 at a clock edge SHALL enter IDLE; o_adc_conv=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_err=0, o_sample_cnt=0, latched config=0.
REQ-023 Reset mid-capture SHALL abort immediately with the above values and no o_done; reset overrides i_start and i_stop.

Verification
REQ-024 freq=240, size=4, ADC done 20 cycles after each conv, wr_ready tied 1 -> 4 conv pulses 240 cycles apart, addrs 0..3 with matching data, o_done once, o_sample_cnt=4, o_err=0.
REQ-025 i_start with freq=239, or size=0, or size=10001 -> no conv pulse, o_busy=0, o_err=1.
REQ-026 freq=300, size=3, wr_ready held low 400 cycles after first sample -> o_wr_valid/addr/data stable, then o_err=2, o_busy=0, no o_done, o_sample_cnt=0.
REQ-027 freq=250, size=10, i_stop after 3rd write -> IDLE next cycle, o_sample_cnt=3, no o_done, no further conv pulses; i_start during capture ignored.
REQ-028 i_rst asserted during WRITE of 2nd sample -> all outputs at reset values next cycle; subsequent legal start captures normally from address 0.
